instr_fetch_queue: RTL and testbench

//  Decoupled instruction-fetch front end. It sits upstream of the pipeline's F/D register and replaces the

---
 rtl/instr_fetch_queue_pkg.sv | 31 +++
 rtl/instr_fetch_queue_fifo.sv | 83 ++++++++
 rtl/instr_fetch_queue.sv | 131 +++++++++++++
 tb/tb_instr_fetch_queue.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_queue_pkg.sv
// Shared definitions for the instruction-fetch queue: word widths, the NOP
// word presented when the queue is empty, and the buffered entry layout.
package instr_fetch_queue_pkg;

    localparam int XLEN        = 32;
    localparam int IFQ_ENTRY_W = 3 * XLEN;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] RV_NOP = 32'h0000_0013;

    // One buffered fetch: the word plus the two PCs decode needs alongside it.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] instr;
    } ifq_entry_t;

    // What happens to a memory response in the cycle it arrives.
    typedef enum logic [1:0] {
        RSP_NONE,   // no response this cycle
        RSP_DROP,   // belongs to a request issued before a redirect
        RSP_PUSH,   // belongs to the current stream, buffer it
        RSP_ERR     // nothing was outstanding: memory protocol violation
    } rsp_action_e;

    // Sequential word address; wraps modulo 2^32.
    function automatic logic [XLEN-1:0] next_word_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/instr_fetch_queue_fifo.sv
// DEPTH-entry circular buffer of fetched instructions. Pointers wrap at DEPTH
// (a power of two), occupancy is tracked explicitly so full and empty are
// distinguishable. Flush empties the buffer in one cycle.
module ifq_fifo
    import instr_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  ifq_entry_t             push_entry_i,
    output ifq_entry_t             head_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    ifq_entry_t    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    // A pop needs data; a push needs room, which a same-cycle pop provides.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != FULL) || do_pop);

    // Next pointer/occupancy; flush overrides any push or pop.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path leaves it unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage written on push.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; count_q gates
        // whether any entry is visible, so stale contents are never consumed.
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Decoupled instruction-fetch front end. Issues in-order word fetches to a
// multi-cycle instruction memory, buffers returned words with their PCs, and
// presents the oldest one to decode. A redirect flushes the buffer and turns
// every outstanding request into one whose response will be discarded.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req_valid,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_req_ready,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pc_plus4,
    input  logic            instr_ready,
    output logic            protocol_err
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = CW + 2;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q,   rsp_pc_d;
    logic [CW-1:0]   live_q,     live_d;
    logic [CW-1:0]   stale_q,    stale_d;
    logic            perr_q,     perr_d;

    logic [CW-1:0]   fifo_count;
    ifq_entry_t      fifo_head;
    ifq_entry_t      push_entry;
    logic [SW-1:0]   issue_sum;
    logic            req_fire;
    logic            fifo_push;
    logic            fifo_pop;
    logic            rsp_consumed;
    rsp_action_e     rsp_action;

    // Every buffered, live or stale request holds one credit; together they
    // may not exceed DEPTH, so a kept response always finds room.
    assign issue_sum     = SW'(fifo_count) + SW'(live_q) + SW'(stale_q);
    assign mem_req_valid = rst && !redirect_valid && (issue_sum < SW'(DEPTH));
    assign mem_req_addr  = fetch_pc_q;
    assign req_fire      = mem_req_valid && mem_req_ready;

    // Classify an arriving response: stale ones go first because responses
    // return in request order and stale requests are older than live ones.
    always_comb begin
        rsp_action = RSP_NONE;
        if (mem_rsp_valid) begin
            if (stale_q != '0)     rsp_action = RSP_DROP;
            else if (live_q != '0) rsp_action = RSP_PUSH;
            else                   rsp_action = RSP_ERR;
        end
    end

    assign rsp_consumed = (rsp_action == RSP_DROP) || (rsp_action == RSP_PUSH);
    assign fifo_push    = (rsp_action == RSP_PUSH) && !redirect_valid;
    assign fifo_pop     = instr_valid && instr_ready && !redirect_valid;

    assign push_entry.pc       = rsp_pc_q;
    assign push_entry.pc_plus4 = next_word_pc(rsp_pc_q);
    assign push_entry.instr    = mem_rsp_data;

    // Next-state for PCs, request counters and the sticky error flag.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        live_d     = live_q;
        stale_d    = stale_q;
        perr_d     = perr_q || (rsp_action == RSP_ERR);
        if (redirect_valid) begin
            // Everything still in flight becomes stale; a response arriving
            // this very cycle retires one of them.
            fetch_pc_d = redirect_pc;
            rsp_pc_d   = redirect_pc;
            live_d     = '0;
            stale_d    = stale_q + live_q - CW'(rsp_consumed);
        end else begin
            if (req_fire) fetch_pc_d = next_word_pc(fetch_pc_q);
            live_d = live_q + CW'(req_fire) - CW'(rsp_action == RSP_PUSH);
            if (rsp_action == RSP_DROP) stale_d = stale_q - CW'(1);
            if (rsp_action == RSP_PUSH) rsp_pc_d = next_word_pc(rsp_pc_q);
        end
    end

    // Front-end state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            live_q     <= '0;
            stale_q    <= '0;
            perr_q     <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            live_q     <= live_d;
            stale_q    <= stale_d;
            perr_q     <= perr_d;
        end
    end

    ifq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (fifo_push),
        .pop_i        (fifo_pop),
        .flush_i      (redirect_valid),
        .push_entry_i (push_entry),
        .head_o       (fifo_head),
        .count_o      (fifo_count)
    );

    assign instr_valid    = (fifo_count != '0);
    assign instr          = instr_valid ? fifo_head.instr : RV_NOP;
    assign instr_pc       = fifo_head.pc;
    assign instr_pc_plus4 = fifo_head.pc_plus4;
    assign protocol_err   = perr_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue. A reference model built from
// queues (outstanding requests tagged with a redirect epoch, a list of
// buffered entries) predicts every output each cycle; directed scenarios add
// checks against hand-derived constants. A second instance with a reset PC
// near 2^32 exercises address wrap-around on the same stimulus.
module tb_instr_fetch_queue;
    import instr_fetch_queue_pkg::*;

    localparam int          DEPTH   = 4;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    typedef struct { logic [31:0] addr; int unsigned epoch; } req_t;
    typedef struct { logic [31:0] addr; int unsigned due;   } mrsp_t;
    typedef struct { logic [31:0] pc;   logic [31:0] data;  } ent_t;

    logic        clk;
    logic        rst;
    logic        mem_req_ready, mem_rsp_valid, redirect_valid, instr_ready;
    logic [31:0] mem_rsp_data, redirect_pc;

    logic        req_valid, instr_valid, protocol_err;
    logic [31:0] req_addr, instr, instr_pc, instr_pc_plus4;
    logic        w_req_valid, w_instr_valid, w_protocol_err;
    logic [31:0] w_req_addr, w_instr, w_instr_pc, w_instr_pc_plus4;

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .mem_req_valid(req_valid), .mem_req_addr(req_addr), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_pc_plus4(instr_pc_plus4), .instr_ready(instr_ready),
        .protocol_err(protocol_err)
    );

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(WRAP_PC)) dut_w (
        .clk(clk), .rst(rst),
        .mem_req_valid(w_req_valid), .mem_req_addr(w_req_addr), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(w_instr_valid), .instr(w_instr), .instr_pc(w_instr_pc),
        .instr_pc_plus4(w_instr_pc_plus4), .instr_ready(instr_ready),
        .protocol_err(w_protocol_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          checks   = 0;
    int          failures = 0;

    // Reference model and memory environment state.
    req_t        out_q[$];
    mrsp_t       mem_q[$];
    ent_t        fifo_m[$];
    logic [31:0] m_fetch_pc = 32'h0;
    int unsigned epoch      = 0;
    bit          m_perr     = 1'b0;
    int unsigned cyc        = 0;
    bit          chk_en     = 1'b0;
    bit          spurious   = 1'b0;
    int          lat_min    = 1;
    int          lat_max    = 1;

    // Values observed in the most recent cycle (mid-cycle sample).
    logic        obs_req_valid, obs_instr_valid, obs_perr;
    logic [31:0] obs_req_addr, obs_instr, obs_instr_pc;
    logic        obs_w_req_valid, obs_w_instr_valid;
    logic [31:0] obs_w_req_addr, obs_w_instr_pc, obs_w_pc4;

    // Scratch used by directed scenarios.
    bit          v_at[16];
    logic [31:0] pc_at[16];
    bit          w_acc_at[16];
    logic [31:0] w_addr_at[16];
    logic [31:0] w_pc_at[16];
    logic [31:0] w_pc4_at[16];
    logic [31:0] wrap_exp[3];
    int          issued;
    bit          got, bad;
    logic [31:0] got_val;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One clock cycle: present a memory response, sample and check the DUT,
    // advance the model and the memory by what happens at the coming edge.
    task automatic cycle();
        bit          from_mem;
        bit          exp_req_valid;
        bit          acc_m, acc_mem, pop_m, kept;
        req_t        r;
        int unsigned due;
        from_mem = 1'b0;
        kept     = 1'b0;
        if (spurious) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = 32'hDEAD_BEEF;
        end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_word(mem_q[0].addr);
            from_mem      = 1'b1;
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = $urandom();
        end
        exp_req_valid = rst && !redirect_valid && (fifo_m.size() + out_q.size() < DEPTH);
        #3;
        obs_req_valid     = req_valid;
        obs_req_addr      = req_addr;
        obs_instr_valid   = instr_valid;
        obs_instr         = instr;
        obs_instr_pc      = instr_pc;
        obs_perr          = protocol_err;
        obs_w_req_valid   = w_req_valid;
        obs_w_req_addr    = w_req_addr;
        obs_w_instr_valid = w_instr_valid;
        obs_w_instr_pc    = w_instr_pc;
        obs_w_pc4         = w_instr_pc_plus4;
        if (chk_en) begin
            check("mem_req_valid", obs_req_valid, exp_req_valid);
            check("mem_req_addr", obs_req_addr, m_fetch_pc);
            check("instr_valid", obs_instr_valid, fifo_m.size() != 0);
            check("instr", obs_instr, (fifo_m.size() != 0) ? fifo_m[0].data : RV_NOP);
            if (fifo_m.size() != 0) begin
                check("instr_pc", obs_instr_pc, fifo_m[0].pc);
                check("instr_pc_plus4", instr_pc_plus4, fifo_m[0].pc + 32'd4);
            end
            check("protocol_err", obs_perr, m_perr);
        end
        acc_m   = exp_req_valid && mem_req_ready;
        acc_mem = req_valid && mem_req_ready;
        pop_m   = (fifo_m.size() != 0) && instr_ready;
        if (!rst) begin
            out_q.delete();
            mem_q.delete();
            fifo_m.delete();
            m_fetch_pc = 32'h0;
            m_perr     = 1'b0;
        end else begin
            if (from_mem) void'(mem_q.pop_front());
            if (acc_mem) begin
                due = cyc + $urandom_range(lat_max, lat_min);
                if (mem_q.size() > 0 && due <= mem_q[$].due) due = mem_q[$].due + 1;
                mem_q.push_back('{req_addr, due});
            end
            if (mem_rsp_valid) begin
                if (out_q.size() == 0) begin
                    m_perr = 1'b1;
                end else begin
                    r    = out_q.pop_front();
                    kept = !redirect_valid && (r.epoch == epoch);
                end
            end
            if (redirect_valid) begin
                fifo_m.delete();
                epoch++;
                m_fetch_pc = redirect_pc;
            end else begin
                if (pop_m) void'(fifo_m.pop_front());
                if (kept) fifo_m.push_back('{r.addr, mem_rsp_data});
                if (acc_m) begin
                    out_q.push_back('{m_fetch_pc, epoch});
                    m_fetch_pc = m_fetch_pc + 32'd4;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        rst = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        wrap_exp[0] = 32'hFFFF_FFF8; wrap_exp[1] = 32'hFFFF_FFFC; wrap_exp[2] = 32'h0000_0000;
        @(posedge clk);
        #1;
        cycle();
        chk_en = 1'b1;

        // Reset state.
        cycle();
        check("rst_req_valid", obs_req_valid, 32'd0);
        check("rst_instr_valid", obs_instr_valid, 32'd0);
        check("rst_instr_nop", obs_instr, RV_NOP);
        check("rst_protocol_err", obs_perr, 32'd0);

        // Zero-wait stream; the wrap instance runs in lockstep.
        rst = 1'b1; mem_req_ready = 1'b1; instr_ready = 1'b1; lat_min = 1; lat_max = 1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            v_at[k]      = obs_instr_valid;
            pc_at[k]     = obs_instr_pc;
            w_acc_at[k]  = obs_w_req_valid && mem_req_ready;
            w_addr_at[k] = obs_w_req_addr;
            w_pc_at[k]   = obs_w_instr_pc;
            w_pc4_at[k]  = obs_w_pc4;
        end
        check("stream_first_req", w_acc_at[0], 32'd1);
        check("stream_not_yet_valid", v_at[1], 32'd0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("stream_valid_%0d", k), v_at[2+k], 32'd1);
            check($sformatf("stream_pc_%0d", k), pc_at[2+k], 32'(4 * k));
        end
        for (int k = 0; k < 3; k++) begin
            check($sformatf("wrap_issue_%0d", k), w_acc_at[k], 32'd1);
            check($sformatf("wrap_addr_%0d", k), w_addr_at[k], wrap_exp[k]);
        end
        check("wrap_pc4_2nd", w_pc4_at[3], 32'h0);
        check("wrap_pc_3rd", w_pc_at[4], 32'h0);

        // Backpressure: decode stalled, exactly DEPTH fetches issue.
        rst = 1'b0; cycle();
        rst = 1'b1; instr_ready = 1'b0; issued = 0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (obs_req_valid && mem_req_ready) issued++;
        end
        check("bp_issued", 32'(issued), 32'(DEPTH));
        check("bp_req_blocked", obs_req_valid, 32'd0);
        check("bp_head_valid", obs_instr_valid, 32'd1);
        instr_ready = 1'b1; got = 1'b0; got_val = '0;
        for (int k = 0; k < 8 && !got; k++) begin
            cycle();
            if (obs_req_valid && mem_req_ready) begin
                got = 1'b1; got_val = obs_req_addr;
            end
        end
        check("bp_refill_seen", got, 32'd1);
        check("bp_refill_addr", got_val, 32'h10);

        // Redirect with three requests in flight on a 3-cycle memory.
        rst = 1'b0; cycle();
        rst = 1'b1; lat_min = 3; lat_max = 3;
        for (int k = 0; k < 3; k++) cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        cycle();
        redirect_valid = 1'b0; got = 1'b0; bad = 1'b0; got_val = '0;
        for (int k = 0; k < 14; k++) begin
            cycle();
            if (obs_instr_valid) begin
                if (!got) got_val = obs_instr_pc;
                got = 1'b1;
                if (obs_instr_pc < 32'h100) bad = 1'b1;
            end
        end
        check("redir3_first_pc", got_val, 32'h100);
        check("redir3_no_stale", bad, 32'd0);

        // Redirect coinciding with a response and a pop.
        rst = 1'b0; cycle();
        rst = 1'b1; lat_min = 1; lat_max = 1;
        for (int k = 0; k < 4; k++) cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        cycle();
        check("redir_pop_had_head", obs_instr_valid, 32'd1);
        redirect_valid = 1'b0;
        cycle();
        check("redir_flushed", obs_instr_valid, 32'd0);
        check("redir_nop", obs_instr, RV_NOP);
        got = 1'b0; got_val = '0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            if (obs_instr_valid && !got) begin
                got = 1'b1; got_val = obs_instr_pc;
            end
        end
        check("redir_new_pc", got_val, 32'h200);

        // Spurious response with nothing outstanding.
        rst = 1'b0; cycle();
        rst = 1'b1; mem_req_ready = 1'b0; instr_ready = 1'b0; spurious = 1'b1;
        cycle();
        spurious = 1'b0;
        cycle();
        check("perr_set", obs_perr, 32'd1);
        check("perr_fifo_empty", obs_instr_valid, 32'd0);
        for (int k = 0; k < 3; k++) cycle();
        check("perr_sticky", obs_perr, 32'd1);
        rst = 1'b0; cycle();
        rst = 1'b1; cycle();
        check("perr_cleared", obs_perr, 32'd0);
        check("perr_clr_instr", obs_instr, RV_NOP);

        // Randomized traffic with variable memory latency, redirects and resets.
        lat_min = 1; lat_max = 3;
        for (int k = 0; k < 1500; k++) begin
            mem_req_ready  = ($urandom_range(0, 3) != 0);
            instr_ready    = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 24) == 0);
            redirect_pc    = $urandom() & 32'hFFFF_FFFC;
            rst            = ($urandom_range(0, 299) != 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
